// File: rtl/bomb_pkg.sv
// Shared types and widths for the bomb slot logic.
package bomb_pkg;

    localparam int COL_W_DEFAULT = 5;
    localparam int ROW_W_DEFAULT = 4;
    localparam int TICK_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        EXPLODING = 2'd2
    } bomb_state_t;

endpackage

// File: rtl/bomb_fuse_timer_tick_event_counter.sv
// Counts qua_sec pulses from 0 up to limit-1, then wraps to 0; terminal flags the last count.
module tick_event_counter
    import bomb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  tick_i,
    input  logic [TICK_CNT_W-1:0] limit_i,
    output logic [TICK_CNT_W-1:0] count_o,
    output logic                  terminal_o
);

    logic [TICK_CNT_W-1:0] count_q, count_d;

    assign count_o    = count_q;
    assign terminal_o = (count_q == (limit_i - TICK_CNT_W'(1)));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = terminal_o ? '0 : count_q + TICK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bomb_fuse_timer.sv
// One bomb slot: place -> fuse countdown in quarter seconds -> explosion window -> free.
module bomb_fuse_timer
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS    = 12,
    parameter int EXPLODE_TICKS = 4,
    parameter int WARN_TICKS    = 4,
    parameter int COL_W         = COL_W_DEFAULT,
    parameter int ROW_W         = ROW_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             qua_sec,
    input  logic             place_bomb,
    input  logic [COL_W-1:0] place_col,
    input  logic [ROW_W-1:0] place_row,
    input  logic             chain_hit,
    output logic             place_ack,
    output logic             bomb_active,
    output logic             bomb_visible,
    output logic [COL_W-1:0] bomb_col,
    output logic [ROW_W-1:0] bomb_row,
    output logic             exploding,
    output logic             explode_start,
    output logic             bomb_done,
    output bomb_state_t      state_dbg
);

    localparam logic [TICK_CNT_W-1:0] FUSE_LIM = TICK_CNT_W'(FUSE_TICKS);
    localparam logic [TICK_CNT_W-1:0] EXPL_LIM = TICK_CNT_W'(EXPLODE_TICKS);
    localparam logic [TICK_CNT_W:0]   FUSE_X   = (TICK_CNT_W+1)'(FUSE_TICKS);
    localparam logic [TICK_CNT_W:0]   WARN_X   = (TICK_CNT_W+1)'(WARN_TICKS);

    bomb_state_t           state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  blink_q, blink_d;
    logic                  ack_q, ack_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;

    logic                  cnt_clear, cnt_tick, cnt_terminal;
    logic [TICK_CNT_W-1:0] cnt_limit, tick_cnt;
    logic [TICK_CNT_W:0]   remaining;
    logic                  warn_now, warn_after_tick;

    assign cnt_limit = (state_q == EXPLODING) ? EXPL_LIM : FUSE_LIM;

    tick_event_counter u_tick_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .tick_i     (cnt_tick),
        .limit_i    (cnt_limit),
        .count_o    (tick_cnt),
        .terminal_o (cnt_terminal)
    );

    // Blink phase flips on the tick that lands in the warning zone, so the
    // first warning quarter second is drawn dark.
    assign remaining       = FUSE_X - {1'b0, tick_cnt};
    assign warn_now        = (remaining <= WARN_X);
    assign warn_after_tick = ((remaining - (TICK_CNT_W+1)'(1)) <= WARN_X);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        blink_d   = blink_q;
        ack_d     = 1'b0;
        start_d   = 1'b0;
        done_d    = 1'b0;
        cnt_clear = 1'b0;
        cnt_tick  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (place_bomb) begin
                    state_d = ARMED;
                    col_d   = place_col;
                    row_d   = place_row;
                    blink_d = 1'b1;
                    ack_d   = 1'b1;
                end
            end
            ARMED: begin
                if (chain_hit) begin
                    state_d   = EXPLODING;
                    cnt_clear = 1'b1;
                    start_d   = 1'b1;
                end else if (qua_sec) begin
                    cnt_tick = 1'b1;
                    if (cnt_terminal) begin
                        state_d = EXPLODING;
                        start_d = 1'b1;
                    end else if (warn_after_tick) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            EXPLODING: begin
                if (qua_sec) begin
                    cnt_tick = 1'b1;
                    if (cnt_terminal) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            blink_q <= 1'b1;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            blink_q <= blink_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign place_ack     = ack_q;
    assign bomb_active   = (state_q == ARMED);
    assign bomb_visible  = (state_q == ARMED) && (!warn_now || blink_q);
    assign bomb_col      = col_q;
    assign bomb_row      = row_q;
    assign exploding     = (state_q == EXPLODING);
    assign explode_start = start_q;
    assign bomb_done     = done_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_bomb_fuse_timer.sv
// Bench for bomb_fuse_timer: scenario tasks plus a countdown-based reference model.
module tb_bomb_fuse_timer;
    import bomb_pkg::*;

    localparam int FUSE = 12;
    localparam int EXPL = 4;
    localparam int WARN = 4;
    localparam int CW   = 5;
    localparam int RW   = 4;
    localparam int OW   = 6 + CW + RW + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          qua_sec = 1'b0;
    logic          place_bomb = 1'b0;
    logic [CW-1:0] place_col = '0;
    logic [RW-1:0] place_row = '0;
    logic          chain_hit = 1'b0;
    logic          place_ack, bomb_active, bomb_visible, exploding, explode_start, bomb_done;
    logic [CW-1:0] bomb_col;
    logic [RW-1:0] bomb_row;
    bomb_state_t   state_dbg;

    always #5 clk = ~clk;

    bomb_fuse_timer #(
        .FUSE_TICKS(FUSE), .EXPLODE_TICKS(EXPL), .WARN_TICKS(WARN), .COL_W(CW), .ROW_W(RW)
    ) dut (
        .clk(clk), .reset(reset), .qua_sec(qua_sec), .place_bomb(place_bomb),
        .place_col(place_col), .place_row(place_row), .chain_hit(chain_hit),
        .place_ack(place_ack), .bomb_active(bomb_active), .bomb_visible(bomb_visible),
        .bomb_col(bomb_col), .bomb_row(bomb_row), .exploding(exploding),
        .explode_start(explode_start), .bomb_done(bomb_done), .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    // Reference model: 0 free, 1 armed, 2 exploding; fuse and blast count down.
    int            m_mode = 0;
    int            m_fuse_left = 0;
    int            m_blast_left = 0;
    logic          m_blink = 1'b1;
    logic [CW-1:0] m_col = '0;
    logic [RW-1:0] m_row = '0;
    logic          m_ack = 1'b0, m_start = 1'b0, m_done = 1'b0;

    wire [OW-1:0] obs = {place_ack, bomb_active, bomb_visible, exploding, explode_start,
                         bomb_done, bomb_col, bomb_row, 2'(state_dbg)};

    function automatic logic [OW-1:0] model_vec();
        logic vis;
        vis = (m_mode == 1) && ((m_fuse_left > WARN) || m_blink);
        return {m_ack, (m_mode == 1), vis, (m_mode == 2), m_start, m_done, m_col, m_row, 2'(m_mode)};
    endfunction

    task automatic model_edge();
        m_ack = 1'b0; m_start = 1'b0; m_done = 1'b0;
        if (reset) begin
            m_mode = 0; m_col = '0; m_row = '0; m_blink = 1'b1;
            m_fuse_left = 0; m_blast_left = 0;
        end else begin
            case (m_mode)
                0: if (place_bomb) begin
                    m_mode = 1; m_fuse_left = FUSE; m_col = place_col; m_row = place_row;
                    m_blink = 1'b1; m_ack = 1'b1;
                end
                1: if (chain_hit) begin
                    m_mode = 2; m_blast_left = EXPL; m_start = 1'b1;
                end else if (qua_sec) begin
                    m_fuse_left--;
                    if (m_fuse_left == 0) begin
                        m_mode = 2; m_blast_left = EXPL; m_start = 1'b1;
                    end else if (m_fuse_left <= WARN) begin
                        m_blink = ~m_blink;
                    end
                end
                default: if (qua_sec) begin
                    m_blast_left--;
                    if (m_blast_left == 0) begin
                        m_mode = 0; m_done = 1'b1;
                    end
                end
            endcase
        end
    endtask

    // One clock: quarter-second tick every 8 clocks, model follows the edge.
    task automatic step();
        qua_sec = (phase == 7);
        phase = (phase + 1) % 8;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_state obs=%h exp=0", obs);
        end
        reset = 1'b0;
        step();
        checks++;
        if (obs !== model_vec()) begin
            errors++; $display("FAIL reset_release obs=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_fuse();
        int k = 0;
        int budget = 0;
        bit seen_start = 0;
        logic vis_exp;
        place_col = 5'd7; place_row = 4'd3; place_bomb = 1'b1;
        step();
        place_bomb = 1'b0;
        checks++;
        if (place_ack !== 1'b1 || bomb_active !== 1'b1 || bomb_col !== 5'd7 || bomb_row !== 4'd3) begin
            errors++;
            $display("FAIL place_accept ack=%b active=%b col=%0d row=%0d exp 1 1 7 3",
                     place_ack, bomb_active, bomb_col, bomb_row);
        end
        while (!seen_start && budget < 200) begin
            if (bomb_active) begin
                vis_exp = (k < FUSE - WARN) ? 1'b1 : ((k - (FUSE - WARN)) % 2 == 1);
                checks++;
                if (bomb_visible !== vis_exp) begin
                    errors++; $display("FAIL blink tick=%0d visible=%b exp=%b", k, bomb_visible, vis_exp);
                end
            end
            step();
            budget++;
            if (qua_sec) k++;
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL fuse_model cyc=%0d obs=%h exp=%h", budget, obs, model_vec());
            end
            if (explode_start) seen_start = 1;
        end
        checks++;
        if (!seen_start || k != FUSE || exploding !== 1'b1 || bomb_visible !== 1'b0) begin
            errors++;
            $display("FAIL fuse_length start=%0d ticks=%0d exploding=%b visible=%b exp 1 %0d 1 0",
                     seen_start, k, exploding, bomb_visible, FUSE);
        end
    endtask

    task automatic test_explosion();
        int k = 0;
        int budget = 0;
        int extra_done = 0;
        while (!bomb_done && budget < 100) begin
            step();
            budget++;
            if (qua_sec) k++;
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL explode_model cyc=%0d obs=%h exp=%h", budget, obs, model_vec());
            end
        end
        checks++;
        if (bomb_done !== 1'b1 || k != EXPL || exploding !== 1'b0 || state_dbg !== IDLE ||
            bomb_col !== 5'd7 || bomb_row !== 4'd3) begin
            errors++;
            $display("FAIL explode_window done=%b ticks=%0d exploding=%b col=%0d row=%0d exp 1 %0d 0 7 3",
                     bomb_done, k, exploding, bomb_col, bomb_row, EXPL);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (bomb_done) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin
            errors++; $display("FAIL done_once extra=%0d exp=0", extra_done);
        end
    endtask

    task automatic test_chain_hit();
        int k = 0;
        int budget = 0;
        place_col = 5'($urandom_range(0, 31)); place_row = 4'($urandom_range(0, 15));
        place_bomb = 1'b1;
        step();
        place_bomb = 1'b0;
        while (k < 5 && budget < 100) begin
            step(); budget++;
            if (qua_sec) k++;
        end
        while (phase != 7 && budget < 120) begin
            step(); budget++;
        end
        chain_hit = 1'b1;
        step();
        chain_hit = 1'b0;
        checks++;
        if (explode_start !== 1'b1 || exploding !== 1'b1 || qua_sec !== 1'b1 || obs !== model_vec()) begin
            errors++;
            $display("FAIL chain_start start=%b exploding=%b tick=%b obs=%h exp=%h",
                     explode_start, exploding, qua_sec, obs, model_vec());
        end
        k = 0; budget = 0;
        while (!bomb_done && budget < 100) begin
            step(); budget++;
            if (qua_sec) k++;
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL chain_model cyc=%0d obs=%h exp=%h", budget, obs, model_vec());
            end
        end
        checks++;
        if (bomb_done !== 1'b1 || k != EXPL) begin
            errors++; $display("FAIL chain_window done=%b ticks=%0d exp 1 %0d", bomb_done, k, EXPL);
        end
    endtask

    task automatic test_place_ignored();
        int budget = 0;
        place_col = 5'd9; place_row = 4'd2; place_bomb = 1'b1;
        step();
        checks++;
        if (place_ack !== 1'b1 || bomb_col !== 5'd9) begin
            errors++; $display("FAIL busy_first_place ack=%b col=%0d exp 1 9", place_ack, bomb_col);
        end
        place_col = 5'd1; place_row = 4'd5;
        while (!bomb_done && budget < 200) begin
            step(); budget++;
            checks++;
            if (place_ack !== 1'b0 || (!bomb_done && bomb_col !== 5'd9) || obs !== model_vec()) begin
                errors++;
                $display("FAIL busy_ignore cyc=%0d ack=%b col=%0d obs=%h exp=%h",
                         budget, place_ack, bomb_col, obs, model_vec());
            end
        end
        step();
        place_bomb = 1'b0;
        checks++;
        if (place_ack !== 1'b1 || bomb_active !== 1'b1 || bomb_col !== 5'd1 || bomb_row !== 4'd5) begin
            errors++;
            $display("FAIL held_place ack=%b active=%b col=%0d row=%0d exp 1 1 1 5",
                     place_ack, bomb_active, bomb_col, bomb_row);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int budget = 0;
        int pulses = 0;
        while (k < 6 && budget < 100) begin
            step(); budget++;
            if (qua_sec) k++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_armed obs=%h exp=0", obs);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (explode_start || bomb_done || place_ack) pulses++;
        end
        checks++;
        if (pulses != 0 || obs !== model_vec()) begin
            errors++; $display("FAIL reset_quiet pulses=%0d obs=%h exp=%h", pulses, obs, model_vec());
        end
        place_col = 5'd20; place_row = 4'd11; place_bomb = 1'b1;
        step();
        place_bomb = 1'b0;
        checks++;
        if (place_ack !== 1'b1 || bomb_col !== 5'd20 || bomb_row !== 4'd11 || obs !== model_vec()) begin
            errors++; $display("FAIL reset_replace obs=%h exp=%h", obs, model_vec());
        end
        chain_hit = 1'b1;
        step();
        chain_hit = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_exploding obs=%h exp=0", obs);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            place_bomb = ($urandom_range(0, 3) == 0);
            place_col  = 5'($urandom_range(0, 31));
            place_row  = 4'($urandom_range(0, 15));
            chain_hit  = ($urandom_range(0, 29) == 0);
            step();
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, model_vec());
            end
        end
        reset = 1'b0; place_bomb = 1'b0; chain_hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fuse();
        test_explosion();
        test_chain_hit();
        test_place_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bomb_fuse_timer.md
Name: bomb_fuse_timer

Overview:
- Downstream consumer of the quarter-second tick (`qua_sec`, a one-cycle pulse every 12,500,000 clocks).
- Owns the life cycle of one player bomb: place → fuse countdown in quarter seconds → explosion window → free.
- Feeds the bomb/explosion drawing objects and the collision logic: position, blink-warning flag, explosion status, event pulses.
- One instance per bomb slot.

Parameters:
- FUSE_TICKS, 12, quarter-second ticks from arming to detonation (3 s); legal range 2..255.
- EXPLODE_TICKS, 4, quarter-second ticks the explosion stays active (1 s); legal range 1..255.
- WARN_TICKS, 4, remaining fuse ticks at or below which the bomb blinks.
- COL_W, 5, tile column width.
- ROW_W, 4, tile row width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- qua_sec  in  1  one-cycle quarter-second tick from the tick counter.
- place_bomb  in  1  request to drop a bomb; level or pulse.
- place_col  in  COL_W  tile column of the request.
- place_row  in  ROW_W  tile row of the request.
- chain_hit  in  1  another explosion covers this bomb's tile; forces early detonation.
- place_ack  out  1  one-cycle pulse, request accepted.
- bomb_active  out  1  bomb present on the map (ARMED).
- bomb_visible  out  1  draw enable for the bomb sprite; implements blink.
- bomb_col  out  COL_W  latched column.
- bomb_row  out  ROW_W  latched row.
- exploding  out  1  explosion window active (EXPLODING).
- explode_start  out  1  one-cycle pulse on entry to EXPLODING.
- bomb_done  out  1  one-cycle pulse when EXPLODING ends.

Behaviour:
- States: IDLE, ARMED, EXPLODING. Registered state; all outputs registered or decoded from registered state/counter only.
- Reset (synchronous, priority over everything):
  - state = IDLE, tick_cnt = 0, blink_ph = 1.
  - bomb_col = 0, bomb_row = 0.
  - All outputs low except bomb_visible = 0.
- IDLE:
  - place_bomb=1 → next cycle: ARMED; latch place_col/place_row; tick_cnt = 0; blink_ph = 1.
  - place_ack = 1 for that one cycle (asserted in the cycle state becomes ARMED).
  - qua_sec and chain_hit ignored.
- ARMED:
  - bomb_active = 1.
  - On qua_sec with tick_cnt < FUSE_TICKS-1: tick_cnt += 1.
  - On qua_sec with tick_cnt == FUSE_TICKS-1: next state EXPLODING, tick_cnt = 0.
  - chain_hit = 1: next state EXPLODING, tick_cnt = 0, regardless of qua_sec. chain_hit has priority when both are asserted.
  - place_bomb ignored, no ack. Latched position is frozen until the next accepted placement.
  - Fuse latency: arming is asynchronous to the tick, so real fuse time lies in ((FUSE_TICKS-1)·0.25 s, FUSE_TICKS·0.25 s].
- Blink:
  - remaining = FUSE_TICKS - tick_cnt.
  - While remaining > WARN_TICKS: bomb_visible = 1.
  - Otherwise blink_ph toggles on each qua_sec and bomb_visible = blink_ph.
  - bomb_visible = 0 outside ARMED.
- EXPLODING:
  - exploding = 1; explode_start = 1 only in the first cycle.
  - On qua_sec with tick_cnt == EXPLODE_TICKS-1: next state IDLE, bomb_done = 1 for one cycle (the first IDLE cycle), tick_cnt = 0.
  - Otherwise qua_sec increments tick_cnt.
  - chain_hit and place_bomb ignored.
- A place_bomb held high through the EXPLODING→IDLE transition is accepted in the first IDLE cycle; place_ack fires 1 cycle after bomb_done.
- bomb_col/bomb_row remain valid during EXPLODING and hold their last value in IDLE.
- tick_cnt width: 8 bits, unsigned; never wraps because the compare resets it.
- Reset mid-ARMED or mid-EXPLODING: immediate return to IDLE, no bomb_done or explode_start pulse.

Decomposition:
- Package bomb_pkg holds:
  - state enum bomb_state_t {IDLE, ARMED, EXPLODING};
  - COL_W/ROW_W defaults;
  - TICK_CNT_W = 8.
- Natural sub-module: tick_event_counter.
  - Counts qua_sec pulses up to a runtime limit.
  - Has clear, terminal-count output and current count.
  - Instantiated once; the limit is muxed between FUSE_TICKS and EXPLODE_TICKS by state.

Test Plan (bench drives qua_sec every 8 clocks for speed; FUSE_TICKS=12, EXPLODE_TICKS=4, WARN_TICKS=4):
1. Reset, then place_bomb with col=7, row=3 → place_ack one cycle later; bomb_active=1, bomb_col=7, bomb_row=3. After the 12th tick: explode_start pulse, exploding=1.
2. Explosion window: count 4 ticks after explode_start → bomb_done pulse exactly once, exploding=0, state IDLE, position still 7/3.
3. Blink: bomb_visible=1 for ticks 0–7; from tick_cnt=8 it toggles on every tick (0,1,0,1); bomb_visible=0 once exploding.
4. chain_hit at tick_cnt=5, coinciding with qua_sec → explode_start next cycle; tick_cnt restarts at 0; the exploding window is a full 4 ticks.
5. place_bomb with col=1 while ARMED or EXPLODING → no place_ack, bomb_col unchanged. place_bomb held across the end of EXPLODING → place_ack 1 cycle after bomb_done, new position latched.
6. reset asserted at tick_cnt=6 in ARMED → next cycle all outputs 0, no pulses. A following place_bomb is accepted normally.
